// File: rtl/emergency_request_manager_pkg.sv
// Shared types for the emergency request manager and the downstream traffic controller.
// Holds the direction encoding, the lane-state encoding and a small popcount helper.
package emergency_request_manager_pkg;

    localparam int NUM_LANES = 4;
    localparam int CNT_W     = 8;

    typedef enum logic [1:0] {
        EAST  = 2'd0,
        NORTH = 2'd1,
        WEST  = 2'd2,
        SOUTH = 2'd3
    } direction_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DEBOUNCE = 3'd1,
        PENDING  = 3'd2,
        SERVING  = 3'd3,
        COOLDOWN = 3'd4
    } lane_state_t;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/emergency_lane_fsm.sv
// One lane of the emergency request manager: debounces its detector, holds the request
// until the controller grants the lane, then masks the detector for a cooldown period.
module emergency_lane_fsm
    import emergency_request_manager_pkg::*;
#(
    parameter int         DEBOUNCE_CYCLES = 4,
    parameter int         COOLDOWN_CYCLES = 8,
    parameter int         MAX_WAIT        = 200,
    parameter direction_t LANE            = EAST
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sensor,
    input  logic [1:0]  current_free_path,
    output logic        emergency,
    output logic        stale,
    output logic        emergency_next,
    output lane_state_t state_dbg
);

    localparam logic [CNT_W-1:0] DEB_LIM  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] COOL_LIM = CNT_W'(COOLDOWN_CYCLES);
    localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

    lane_state_t      state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             path_match;
    logic             stale_next;

    assign path_match = (current_free_path == LANE);
    assign state_dbg  = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            emergency <= 1'b0;
            stale     <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            emergency <= emergency_next;
            stale     <= stale_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (sensor) begin
                    state_next = DEBOUNCE;
                    cnt_next   = 8'd1;
                end
            end
            DEBOUNCE: begin
                if (!sensor) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt >= DEB_LIM) begin
                    // Already holding right of way: go straight to serving, no request.
                    state_next = path_match ? SERVING : PENDING;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            PENDING: begin
                if (path_match) begin
                    state_next = SERVING;
                    cnt_next   = '0;
                end else if (cnt != CNT_SAT) begin
                    cnt_next = cnt + 8'd1;
                end
            end
            SERVING: begin
                if (!path_match) begin
                    state_next = COOLDOWN;
                    cnt_next   = 8'd1;
                end
            end
            COOLDOWN: begin
                if (cnt >= COOL_LIM) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they track the state entered on each edge.
    assign emergency_next = (state_next == PENDING);
    assign stale_next     = emergency_next && (cnt_next >= WAIT_LIM);

endmodule

// File: rtl/emergency_request_manager.sv
// Four independent emergency lanes feeding the traffic controller's emergency input.
// No arbitration here; the top only gathers the lane outputs and counts active requests.
module emergency_request_manager
    import emergency_request_manager_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int COOLDOWN_CYCLES = 8,
    parameter int MAX_WAIT        = 200
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            sensor_in,
    input  logic [1:0]            current_free_path,
    output logic [3:0]            emergency,
    output logic [3:0]            stale,
    output logic [2:0]            pending_count,
    output lane_state_t [3:0]     lane_state
);

    logic [3:0] emergency_next;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        emergency_lane_fsm #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .COOLDOWN_CYCLES (COOLDOWN_CYCLES),
            .MAX_WAIT        (MAX_WAIT),
            .LANE            (direction_t'(i))
        ) u_lane (
            .clk               (clk),
            .reset             (reset),
            .sensor            (sensor_in[i]),
            .current_free_path (current_free_path),
            .emergency         (emergency[i]),
            .stale             (stale[i]),
            .emergency_next    (emergency_next[i]),
            .state_dbg         (lane_state[i])
        );
    end

    // Counted from the lanes' next request bits so the count lands on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_count <= '0;
        end else begin
            pending_count <= popcount4(emergency_next);
        end
    end

endmodule
